// File: rtl/ntt_addr_pkg.sv
// Shared types and arithmetic for the NTT/INTT butterfly address sequencer.
// The lane math works on 32-bit values; callers truncate to LOG_N bits.
package ntt_addr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    localparam int N_DEF     = 256;
    localparam int LOG_N_DEF = 8;
    localparam int LANES_DEF = 2;
    localparam int B         = N_DEF / (2 * LANES_DEF);

    typedef struct packed {
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] tf;
    } lane_res_t;

    function automatic int beats_per_stage(input int n, input int lanes);
        return n / (2 * lanes);
    endfunction

    // NTT halves the span every stage starting from N/2; INTT doubles it from 1.
    function automatic int unsigned half_log2(input int unsigned s, input int unsigned log_n,
                                              input logic intt);
        return intt ? s : (log_n - 32'd1 - s);
    endfunction

    function automatic lane_res_t lane_calc(input int unsigned s, input int unsigned b,
                                            input logic intt, input int unsigned log_n);
        lane_res_t   r;
        int unsigned lh;
        int unsigned h;
        int unsigned g;
        int unsigned j;
        int unsigned a;
        int unsigned e;
        int unsigned n;
        int unsigned mask;
        n    = 32'd1 << log_n;
        mask = n - 32'd1;
        lh   = half_log2(s, log_n, intt);
        h    = 32'd1 << lh;
        g    = b >> lh;
        j    = b & (h - 32'd1);
        a    = (g << (lh + 32'd1)) + j;
        e    = j << (log_n - 32'd1 - lh);
        r.addr_a = a & mask;
        r.addr_b = (a + h) & mask;
        r.tf     = intt ? ((n - e) & mask) : (e & mask);
        return r;
    endfunction

endpackage

// File: rtl/ntt_addr_lane.sv
// Combinational address/twiddle generator for one butterfly of a stage.
module ntt_addr_lane
    import ntt_addr_pkg::*;
#(
    parameter int LOG_N = 8
) (
    input  logic [LOG_N-1:0] s,
    input  logic [LOG_N-1:0] b,
    input  logic             is_intt,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [LOG_N-1:0] tf_idx
);

    lane_res_t res;
    logic      unused_hi;

    always_comb begin
        res = lane_calc(32'(s), 32'(b), is_intt, 32'(LOG_N));
    end

    assign addr_a    = res.addr_a[LOG_N-1:0];
    assign addr_b    = res.addr_b[LOG_N-1:0];
    assign tf_idx    = res.tf[LOG_N-1:0];
    assign unused_hi = ^{res.addr_a[31:LOG_N], res.addr_b[31:LOG_N], res.tf[31:LOG_N]};

endmodule

// File: rtl/ntt_addr_seq.sv
// Self-sequencing NTT/INTT address generator: walks all stages after one start,
// emitting LANES butterflies per valid/ready beat with a bubble between stages.
module ntt_addr_seq
    import ntt_addr_pkg::*;
#(
    parameter int N         = 256,
    parameter int LOG_N     = 8,
    parameter int LANES     = 2,
    parameter int STAGE_GAP = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   is_intt,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*LOG_N-1:0] addr_a,
    output logic [LANES*LOG_N-1:0] addr_b,
    output logic [LANES*LOG_N-1:0] tf_idx,
    output logic [LOG_N-1:0]       stage,
    output logic                   last_in_stage,
    output logic                   last,
    output logic                   done
);

    localparam int               BL         = beats_per_stage(N, LANES);
    localparam logic [LOG_N-1:0] LAST_BEAT  = LOG_N'(BL - 1);
    localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);

    state_t                 state_q, state_d;
    logic [LOG_N-1:0]       stage_q, stage_d;
    logic [LOG_N-1:0]       beat_q, beat_d;
    logic [3:0]             gap_q, gap_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   lis_q, lis_d;
    logic                   last_q, last_d;
    logic [LANES*LOG_N-1:0] addr_a_q, addr_a_d;
    logic [LANES*LOG_N-1:0] addr_b_q, addr_b_d;
    logic [LANES*LOG_N-1:0] tf_q, tf_d;

    // Coordinates of the beat being loaded this edge; lanes compute from these.
    logic [LOG_N-1:0]       nxt_stage;
    logic [LOG_N-1:0]       nxt_beat;
    logic                   nxt_mode;
    logic                   load;
    logic [LANES*LOG_N-1:0] lane_a;
    logic [LANES*LOG_N-1:0] lane_b;
    logic [LANES*LOG_N-1:0] lane_tf;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        ntt_addr_lane #(
            .LOG_N(LOG_N)
        ) u_lane (
            .s      (nxt_stage),
            .b      (LOG_N'(32'(nxt_beat) * 32'(LANES) + 32'(gi))),
            .is_intt(nxt_mode),
            .addr_a (lane_a[gi*LOG_N +: LOG_N]),
            .addr_b (lane_b[gi*LOG_N +: LOG_N]),
            .tf_idx (lane_tf[gi*LOG_N +: LOG_N])
        );
    end

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        lis_d     = lis_q;
        last_d    = last_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        tf_d      = tf_q;
        nxt_stage = stage_q;
        nxt_beat  = beat_q;
        nxt_mode  = mode_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle still sits in IDLE, so it must not accept a start.
                if (start && !done_q) begin
                    nxt_stage = '0;
                    nxt_beat  = '0;
                    nxt_mode  = is_intt;
                    mode_d    = is_intt;
                    load      = 1'b1;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (valid_q && out_ready) begin
                    if (beat_q != LAST_BEAT) begin
                        nxt_beat = beat_q + 1'b1;
                        load     = 1'b1;
                    end else if (stage_q == LAST_STAGE) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        lis_d   = 1'b0;
                        last_d  = 1'b0;
                    end else if (STAGE_GAP == 0) begin
                        nxt_stage = stage_q + 1'b1;
                        nxt_beat  = '0;
                        load      = 1'b1;
                    end else begin
                        state_d = GAP;
                        valid_d = 1'b0;
                        gap_d   = 4'(STAGE_GAP - 1);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    nxt_stage = stage_q + 1'b1;
                    nxt_beat  = '0;
                    load      = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = RUN;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            stage_d  = nxt_stage;
            beat_d   = nxt_beat;
            addr_a_d = lane_a;
            addr_b_d = lane_b;
            tf_d     = lane_tf;
            lis_d    = (nxt_beat == LAST_BEAT);
            last_d   = (nxt_beat == LAST_BEAT) && (nxt_stage == LAST_STAGE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            lis_q    <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tf_q     <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            lis_q    <= lis_d;
            last_q   <= last_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tf_q     <= tf_d;
        end
    end

    assign busy          = busy_q;
    assign out_valid     = valid_q;
    assign done          = done_q;
    assign addr_a        = addr_a_q;
    assign addr_b        = addr_b_q;
    assign tf_idx        = tf_q;
    assign stage         = stage_q;
    assign last_in_stage = lis_q;
    assign last          = last_q;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Bench for ntt_addr_seq at N=16, LANES=2; one instance without and one with stage bubbles.
module tb_ntt_addr_seq;

    localparam int N     = 16;
    localparam int LOG_N = 4;
    localparam int LANES = 2;
    localparam int B     = N / (2 * LANES);
    localparam int TOT   = LOG_N * B;
    localparam int W     = LANES * LOG_N;

    logic clk;
    logic reset_n;
    logic start;
    logic is_intt;
    logic out_ready;
    int   sel;

    int checks = 0;
    int errors = 0;

    logic         start0, start2;
    logic         busy0, valid0, lis0, last0, done0;
    logic         busy2, valid2, lis2, last2, done2;
    logic [W-1:0] a0, b0, tf0, a2, b2, tf2;
    logic [LOG_N-1:0] stage0, stage2;

    logic         o_busy, o_valid, o_lis, o_last, o_done;
    logic [W-1:0] o_a, o_b, o_tf;
    logic [LOG_N-1:0] o_stage;

    assign start0 = start && (sel == 0);
    assign start2 = start && (sel == 1);

    ntt_addr_seq #(.N(N), .LOG_N(LOG_N), .LANES(LANES), .STAGE_GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .is_intt(is_intt),
        .busy(busy0), .out_valid(valid0), .out_ready(out_ready),
        .addr_a(a0), .addr_b(b0), .tf_idx(tf0), .stage(stage0),
        .last_in_stage(lis0), .last(last0), .done(done0)
    );

    ntt_addr_seq #(.N(N), .LOG_N(LOG_N), .LANES(LANES), .STAGE_GAP(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .is_intt(is_intt),
        .busy(busy2), .out_valid(valid2), .out_ready(out_ready),
        .addr_a(a2), .addr_b(b2), .tf_idx(tf2), .stage(stage2),
        .last_in_stage(lis2), .last(last2), .done(done2)
    );

    always_comb begin
        if (sel == 0) begin
            {o_busy, o_valid, o_lis, o_last, o_done} = {busy0, valid0, lis0, last0, done0};
            {o_a, o_b, o_tf, o_stage} = {a0, b0, tf0, stage0};
        end else begin
            {o_busy, o_valid, o_lis, o_last, o_done} = {busy2, valid2, lis2, last2, done2};
            {o_a, o_b, o_tf, o_stage} = {a2, b2, tf2, stage2};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: butterfly b of stage s pairs (g*2h+j, g*2h+j+h) with twiddle j*N/(2h).
    function automatic int exp_field(input int idx, input int lane, input bit intt, input int which);
        int s, k, b, h, g, j, a, e;
        s = idx / B;
        k = idx % B;
        b = k * LANES + lane;
        h = intt ? (1 << s) : (N >> (s + 1));
        g = b / h;
        j = b % h;
        a = g * 2 * h + j;
        e = j * (N / (2 * h));
        case (which)
            0:       return a % N;
            1:       return (a + h) % N;
            default: return intt ? (N - e) % N : e;
        endcase
    endfunction

    task automatic run_transform(input bit intt, input int gsel, input int rmode, input bit spam);
        int idx, cyc, inval, hold_left, gap, gap_checked, v;
        bit seen_done, held;
        logic [W-1:0] ea, eb, et;
        sel = gsel;
        gap = gsel ? 2 : 0;
        is_intt = intt;
        start = 1'b1;
        out_ready = 1'b1;
        idx = 0; cyc = 0; inval = 0; hold_left = 0; gap_checked = 0;
        seen_done = 1'b0; held = 1'b0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start   = spam ? ($urandom_range(0, 2) == 0) : 1'b0;
            is_intt = spam ? ~intt : intt;
            if (o_done) begin
                seen_done = 1'b1;
                checks++;
                if (idx !== TOT) begin
                    errors++;
                    $display("FAIL handshake_count: got %0d, expected %0d", idx, TOT);
                end
                checks++;
                if ({o_valid, o_busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL done_cycle_flags: valid/busy=%b, expected 00", {o_valid, o_busy});
                end
                if (rmode == 0) begin
                    checks++;
                    if (cyc !== 1 + TOT + (LOG_N - 1) * gap) begin
                        errors++;
                        $display("FAIL start_to_done: got %0d cycles, expected %0d", cyc, 1 + TOT + (LOG_N - 1) * gap);
                    end
                end
            end else if (o_valid) begin
                if (idx >= TOT) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: beat %0d seen beyond %0d", idx, TOT);
                    out_ready = 1'b1;
                end else begin
                    if (idx > 0 && idx % B == 0 && gap_checked != idx) begin
                        gap_checked = idx;
                        checks++;
                        if (inval !== gap) begin
                            errors++;
                            $display("FAIL stage_gap: %0d idle cycles before beat %0d, expected %0d", inval, idx, gap);
                        end
                    end
                    for (int l = 0; l < LANES; l++) begin
                        v = exp_field(idx, l, intt, 0); ea[l*LOG_N +: LOG_N] = LOG_N'(v);
                        v = exp_field(idx, l, intt, 1); eb[l*LOG_N +: LOG_N] = LOG_N'(v);
                        v = exp_field(idx, l, intt, 2); et[l*LOG_N +: LOG_N] = LOG_N'(v);
                    end
                    checks++;
                    if ({o_a, o_b, o_tf} !== {ea, eb, et}) begin
                        errors++;
                        $display("FAIL beat_addr: beat %0d a=%h b=%h tf=%h, expected a=%h b=%h tf=%h",
                                 idx, o_a, o_b, o_tf, ea, eb, et);
                    end
                    checks++;
                    if ({o_stage, o_lis, o_last, o_busy} !== {LOG_N'(idx / B), (idx % B) == B - 1, idx == TOT - 1, 1'b1}) begin
                        errors++;
                        $display("FAIL beat_flags: beat %0d stage=%0d lis=%b last=%b busy=%b, expected stage=%0d lis=%b last=%b busy=1",
                                 idx, o_stage, o_lis, o_last, o_busy, idx / B, (idx % B) == B - 1, idx == TOT - 1);
                    end
                    case (rmode)
                        0: out_ready = 1'b1;
                        1: out_ready = ($urandom_range(0, 3) != 0);
                        default: begin
                            if (idx == 2 && !held) begin
                                held = 1'b1;
                                hold_left = 5;
                            end
                            out_ready = (hold_left == 0);
                            if (hold_left > 0) hold_left--;
                        end
                    endcase
                    if (out_ready) idx++;
                end
                inval = 0;
            end else begin
                inval++;
                out_ready = 1'($urandom_range(0, 1));
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_gap: busy=%b at cycle %0d, expected 1", o_busy, cyc);
                end
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
        start = 1'b0;
        is_intt = intt;
        out_ready = 1'b1;
        $display("transform intt=%0d gap=%0d ready_mode=%0d spam=%0d beats=%0d cycles=%0d",
                 intt, gap, rmode, spam, idx, cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        is_intt = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            checks++;
            if ({o_busy, o_valid, o_done, o_lis, o_last, o_stage, o_a, o_b, o_tf} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: dut%0d busy=%b valid=%b a=%h b=%h tf=%h stage=%0d, expected all 0",
                         d, o_busy, o_valid, o_a, o_b, o_tf, o_stage);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ntt_gap0();      repeat (2) @(negedge clk); run_transform(1'b0, 0, 0, 1'b0); endtask
    task automatic test_intt_gap0();     repeat (2) @(negedge clk); run_transform(1'b1, 0, 0, 1'b0); endtask
    task automatic test_gap2();          repeat (2) @(negedge clk); run_transform(1'b0, 1, 0, 1'b0);
                                         repeat (2) @(negedge clk); run_transform(1'b1, 1, 0, 1'b0); endtask
    task automatic test_backpressure();  repeat (2) @(negedge clk); run_transform(1'b0, 0, 2, 1'b0);
                                         repeat (2) @(negedge clk); run_transform(1'b1, 1, 2, 1'b0); endtask
    task automatic test_start_ignored(); repeat (2) @(negedge clk); run_transform(1'b0, 1, 1, 1'b1);
                                         repeat (2) @(negedge clk); run_transform(1'b1, 0, 1, 1'b1); endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge clk);
        run_transform(1'b1, 0, 0, 1'b0);
        // Start raised in the done cycle must be ignored, then taken one cycle later.
        start = 1'b1;
        is_intt = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL start_in_done_cycle: valid/busy=%b, expected 00", {o_valid, o_busy});
        end
        run_transform(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            repeat (2) @(negedge clk);
            run_transform(1'($urandom_range(0, 1)), $urandom_range(0, 1), 1, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_abort();
        int n;
        bit reached;
        repeat (2) @(negedge clk);
        sel = 1;
        is_intt = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        reached = 1'b0;
        n = 0;
        while (!reached && n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (o_valid && o_stage == 1 && !o_lis) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL abort_reach_stage1: stage 1 not reached in %0d cycles", n);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_valid, o_done, o_lis, o_last, o_stage, o_a, o_b, o_tf} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b stage=%0d a=%h, expected all 0", o_busy, o_valid, o_stage, o_a);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({o_done, o_busy, o_valid} !== 3'b000) begin
                errors++;
                $display("FAIL abort_no_done: done/busy/valid=%b at cycle %0d after reset, expected 000", {o_done, o_busy, o_valid}, c);
            end
        end
        $display("transform aborted by reset in stage 1 after %0d cycles", n);
        run_transform(1'b0, 1, 0, 1'b0);
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_ntt_gap0();
        test_intt_gap0();
        test_gap2();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_abort();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
